// File: rtl/sdram_audio_reader.sv
// -----------------------------------------------------------------------------
// sdram_audio_reader
// Fetches a block of 16-bit audio words from an SDRAM bridge port and buffers
// them in a first-word-fall-through FIFO for a streaming consumer.
//
// Ports
//   clk_clk, reset_reset_n          : clock, async active-low reset
//   start, stop                     : one-cycle control pulses (stop wins)
//   base_addr, num_words, loop_en   : playback window and loop mode
//   bridge_*                        : read-only master on the SDRAM bridge
//   sample_data/valid/ready         : FWFT FIFO head and handshake
//   fifo_level                      : FIFO occupancy
//   busy, done                      : engine not idle / one-cycle completion
//
// state | meaning
// IDLE  | waiting for start
// GAP   | between reads; issues the next read when data remains and FIFO has room
// ISSUE | read request held on the bridge until acknowledge
// DONE  | one-cycle completion pulse, then back to IDLE
// -----------------------------------------------------------------------------
module sdram_audio_reader #(
    parameter int ADDR_W     = 26,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk_clk,
    input  logic                          reset_reset_n,
    input  logic                          start,
    input  logic                          stop,
    input  logic [ADDR_W-1:0]             base_addr,
    input  logic [23:0]                   num_words,
    input  logic                          loop_en,
    output logic [ADDR_W-1:0]             bridge_address,
    output logic [1:0]                    bridge_byte_enable,
    output logic                          bridge_read,
    output logic                          bridge_write,
    output logic [15:0]                   bridge_write_data,
    input  logic                          bridge_acknowledge,
    input  logic [15:0]                   bridge_read_data,
    output logic [15:0]                   sample_data,
    output logic                          sample_valid,
    input  logic                          sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          busy,
    output logic                          done
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   r_base;
    logic [23:0]         r_remaining;
    logic [23:0]         r_num;
    logic                r_stop_pend;
    logic [15:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [LVL_W-1:0]    r_level;

    logic                w_stop_any;
    logic                w_ack;
    logic                w_push;
    logic                w_pop;
    logic                w_flush;
    logic                w_start;
    logic                w_last;
    logic                w_unused_addr_lsb;

    assign w_unused_addr_lsb = base_addr[0];

    // A stop seen during ISSUE is remembered so the outstanding read can finish.
    assign w_stop_any = stop | r_stop_pend;
    assign w_ack      = (r_state == ISSUE) && bridge_acknowledge;
    assign w_push     = w_ack && !w_stop_any;
    assign w_pop      = sample_valid && sample_ready;
    assign w_start    = (r_state == IDLE) && start && !stop;
    assign w_last     = (r_remaining == 24'd1);
    // The FIFO empties on the same edge the engine drops into IDLE due to a stop.
    assign w_flush    = (stop && (r_state != ISSUE)) || (w_ack && w_stop_any);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_next = (num_words == 24'd0) ? DONE : GAP;
                end
            end
            GAP: begin
                if (stop) begin
                    w_next = IDLE;
                end else if ((r_remaining != 24'd0) && (r_level < FULL_LVL)) begin
                    w_next = ISSUE;
                end
            end
            ISSUE: begin
                if (w_ack) begin
                    if (w_stop_any) begin
                        w_next = IDLE;
                    end else if (w_last && !loop_en) begin
                        w_next = DONE;
                    end else begin
                        w_next = GAP;
                    end
                end
            end
            DONE: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_addr      <= '0;
            r_base      <= '0;
            r_remaining <= '0;
            r_num       <= '0;
            r_stop_pend <= 1'b0;
        end else begin
            if (w_start) begin
                r_base      <= {base_addr[ADDR_W-1:1], 1'b0};
                r_addr      <= {base_addr[ADDR_W-1:1], 1'b0};
                r_num       <= num_words;
                r_remaining <= num_words;
            end else if (w_push) begin
                if (w_last && loop_en) begin
                    r_addr      <= r_base;
                    r_remaining <= r_num;
                end else begin
                    r_addr      <= r_addr + ADDR_W'(2);
                    r_remaining <= r_remaining - 24'd1;
                end
            end

            if (r_state == ISSUE) begin
                if (w_ack) begin
                    r_stop_pend <= 1'b0;
                end else if (stop) begin
                    r_stop_pend <= 1'b1;
                end
            end else begin
                r_stop_pend <= 1'b0;
            end
        end
    end

    // Storage needs no reset: sample_data is masked while the FIFO is empty.
    always_ff @(posedge clk_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bridge_read_data;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    assign bridge_address     = r_addr;
    assign bridge_read        = (r_state == ISSUE);
    assign bridge_byte_enable = 2'b11;
    assign bridge_write       = 1'b0;
    assign bridge_write_data  = 16'h0000;

    assign fifo_level   = r_level;
    assign sample_valid = (r_level != '0);
    assign sample_data  = sample_valid ? r_mem[r_rd_ptr] : 16'h0000;

    assign busy = (r_state != IDLE);
    // A stop arriving during DONE suppresses the completion pulse.
    assign done = (r_state == DONE) && !stop;

endmodule

// File: tb/tb_sdram_audio_reader.sv
// -----------------------------------------------------------------------------
// tb_sdram_audio_reader
// Directed scenarios against a request-level model of the reader: the model
// keeps the expected FIFO contents as a queue and the expected read address /
// remaining count as plain integers, and is compared with the DUT on every
// falling edge. A few hand-computed literals pin the model's results.
// -----------------------------------------------------------------------------
module tb_sdram_audio_reader;

    localparam int ADDR_W = 26;
    localparam int DEPTH  = 16;

    logic                clk_clk = 1'b0;
    logic                reset_reset_n;
    logic                start, stop, loop_en, sample_ready;
    logic [ADDR_W-1:0]   base_addr;
    logic [23:0]         num_words;
    logic [ADDR_W-1:0]   bridge_address;
    logic [1:0]          bridge_byte_enable;
    logic                bridge_read, bridge_write;
    logic [15:0]         bridge_write_data;
    logic                bridge_acknowledge;
    logic [15:0]         bridge_read_data;
    logic [15:0]         sample_data;
    logic                sample_valid;
    logic [4:0]          fifo_level;
    logic                busy, done;

    // bus responder
    logic                auto_ack = 1'b0;
    logic [15:0]         auto_data = 16'h0;
    logic                spur_ack;
    logic                ack_en;
    int                  ack_lat;

    assign bridge_acknowledge = auto_ack | spur_ack;
    assign bridge_read_data   = auto_ack ? auto_data : (spur_ack ? 16'hDEAD : 16'h0000);

    sdram_audio_reader #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk_clk            (clk_clk),
        .reset_reset_n      (reset_reset_n),
        .start              (start),
        .stop               (stop),
        .base_addr          (base_addr),
        .num_words          (num_words),
        .loop_en            (loop_en),
        .bridge_address     (bridge_address),
        .bridge_byte_enable (bridge_byte_enable),
        .bridge_read        (bridge_read),
        .bridge_write       (bridge_write),
        .bridge_write_data  (bridge_write_data),
        .bridge_acknowledge (bridge_acknowledge),
        .bridge_read_data   (bridge_read_data),
        .sample_data        (sample_data),
        .sample_valid       (sample_valid),
        .sample_ready       (sample_ready),
        .fifo_level         (fifo_level),
        .busy               (busy),
        .done               (done)
    );

    initial forever #5 clk_clk = ~clk_clk;

    // model state
    logic [15:0]         q[$];
    bit                  m_active, m_req, m_done, m_stop_pend;
    logic [ADDR_W-1:0]   m_addr, m_base;
    int unsigned         m_rem, m_num;

    // observations used by the literal checks
    int                  n_vec = 0;
    int                  n_err = 0;
    int                  cyc = 0;
    int                  done_cnt, done_cyc, ack_cnt, read_cycles;
    logic [ADDR_W-1:0]   rd_log[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_clk);
        #1;
    endtask

    task automatic clear_obs();
        done_cnt = 0; ack_cnt = 0; read_cycles = 0; done_cyc = 0;
        rd_log.delete();
    endtask

    task automatic model_step();
        bit          pop, push, flush;
        logic [15:0] pd;
        pop   = (q.size() != 0) && sample_ready;
        push  = 1'b0;
        flush = 1'b0;
        pd    = 16'h0;
        if (m_done) begin
            m_done = 1'b0;
            if (stop) flush = 1'b1;
        end else if (m_req) begin
            if (stop) m_stop_pend = 1'b1;
            if (bridge_acknowledge) begin
                m_req = 1'b0;
                if (m_stop_pend) begin
                    flush = 1'b1; m_active = 1'b0; m_stop_pend = 1'b0;
                end else begin
                    push   = 1'b1;
                    pd     = bridge_read_data;
                    m_rem  = m_rem - 1;
                    m_addr = m_addr + ADDR_W'(2);
                    if (m_rem == 0) begin
                        if (loop_en) begin
                            m_addr = m_base; m_rem = m_num;
                        end else begin
                            m_active = 1'b0; m_done = 1'b1;
                        end
                    end
                end
            end
        end else if (m_active) begin
            if (stop) begin
                flush = 1'b1; m_active = 1'b0;
            end else if (m_rem > 0 && q.size() < DEPTH) begin
                m_req = 1'b1;
            end
        end else begin
            if (stop) begin
                flush = 1'b1;
            end else if (start) begin
                m_base = {base_addr[ADDR_W-1:1], 1'b0};
                m_addr = m_base;
                m_num  = num_words;
                m_rem  = num_words;
                if (num_words == 24'd0) m_done = 1'b1;
                else m_active = 1'b1;
            end
        end
        if (flush) begin
            q.delete();
        end else begin
            if (pop) void'(q.pop_front());
            if (push) q.push_back(pd);
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk_clk);
            cyc++;
            if (!reset_reset_n) begin
                q.delete();
                m_active = 0; m_req = 0; m_done = 0; m_stop_pend = 0;
                m_addr = '0; m_rem = 0;
                chk("rst_bridge_read", 32'(bridge_read), 0);
                chk("rst_fifo_level", 32'(fifo_level), 0);
                chk("rst_sample_valid", 32'(sample_valid), 0);
                chk("rst_sample_data", 32'(sample_data), 0);
                chk("rst_busy", 32'(busy), 0);
                chk("rst_done", 32'(done), 0);
            end else begin
                chk("bridge_read", 32'(bridge_read), 32'(m_req));
                if (m_req) chk("bridge_address", 32'(bridge_address), 32'(m_addr));
                chk("fifo_level", 32'(fifo_level), 32'(q.size()));
                chk("sample_valid", 32'(sample_valid), 32'(q.size() != 0));
                if (q.size() != 0) chk("sample_data", 32'(sample_data), 32'(q[0]));
                chk("busy", 32'(busy), 32'(m_active || m_done));
                chk("done", 32'(done), 32'(m_done && !stop));
                chk("const_outputs", {13'h0, bridge_write, bridge_byte_enable, bridge_write_data},
                    {13'h0, 1'b0, 2'b11, 16'h0000});
                if (done) begin done_cnt++; done_cyc = cyc; end
                if (bridge_read && bridge_acknowledge) begin
                    ack_cnt++;
                    rd_log.push_back(bridge_address);
                end
                if (bridge_read) read_cycles++;
                model_step();
            end
        end
    endtask

    task automatic ack_driver();
        int cnt = 0;
        forever begin
            @(posedge clk_clk);
            #1;
            auto_ack = 1'b0;
            if (ack_en && bridge_read && reset_reset_n) begin
                cnt++;
                if (cnt >= ack_lat) begin
                    auto_ack  = 1'b1;
                    auto_data = bridge_address[15:0] ^ 16'hA000;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    endtask

    task automatic pulse_start(input logic [ADDR_W-1:0] b, input logic [23:0] n, input logic lp);
        base_addr = b; num_words = n; loop_en = lp;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        tick();
        stop = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy && n < budget) begin tick(); n++; end
        chk({name, "_idle"}, 32'(busy), 0);
    endtask

    initial begin
        logic [ADDR_W-1:0] exp_loop [7];
        logic [15:0]       exp_data [4];
        int                n;
        int                s_cyc;

        exp_loop = '{26'h200, 26'h202, 26'h204, 26'h200, 26'h202, 26'h204, 26'h200};
        exp_data = '{16'hA100, 16'hA102, 16'hA104, 16'hA106};

        start = 0; stop = 0; loop_en = 0; sample_ready = 0;
        base_addr = '0; num_words = '0;
        spur_ack = 0; ack_en = 1; ack_lat = 2;
        reset_reset_n = 1'b1;
        clear_obs();
        fork
            compare_loop();
            ack_driver();
        join_none

        #1 reset_reset_n = 1'b0;
        #1;
        chk("reset_read", 32'(bridge_read), 0);
        chk("reset_level", 32'(fifo_level), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_data", 32'(sample_data), 0);
        repeat (3) tick();
        reset_reset_n = 1'b1;
        repeat (2) tick();

        // basic four-word fetch
        clear_obs();
        pulse_start(26'h100, 24'd4, 1'b0);
        wait_idle(100, "basic");
        chk("basic_acks", 32'(ack_cnt), 4);
        chk("basic_done_cnt", 32'(done_cnt), 1);
        for (int i = 0; i < 4; i++) chk("basic_addr", 32'(rd_log[i]), 32'(26'h100 + 2 * i));
        chk("basic_level", 32'(fifo_level), 4);
        sample_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("basic_drain", 32'(sample_data), 32'(exp_data[i]));
            tick();
        end
        sample_ready = 1'b0;
        chk("basic_empty", 32'(fifo_level), 0);

        // back-pressure: FIFO fills to 16, fetch stalls, then resumes; address wraps
        clear_obs();
        pulse_start(26'h3FFFFE0, 24'd40, 1'b0);
        repeat (120) tick();
        chk("full_acks", 32'(ack_cnt), 16);
        chk("full_level", 32'(fifo_level), 16);
        for (int i = 0; i < 4; i++) begin
            chk("full_no_read", 32'(bridge_read), 0);
            tick();
        end
        sample_ready = 1'b1;
        wait_idle(400, "full");
        chk("full_total_acks", 32'(ack_cnt), 40);
        chk("full_wrap_addr", 32'(rd_log[16]), 0);
        chk("full_done_cnt", 32'(done_cnt), 1);
        repeat (20) tick();
        chk("full_drained", 32'(fifo_level), 0);

        // loop mode; odd base address has bit 0 dropped
        clear_obs();
        pulse_start(26'h201, 24'd3, 1'b1);
        n = 0;
        while (ack_cnt < 7 && n < 200) begin tick(); n++; end
        chk("loop_reached", 32'(ack_cnt >= 7), 1);
        for (int i = 0; i < 7; i++) chk("loop_addr", 32'(rd_log[i]), 32'(exp_loop[i]));
        chk("loop_no_done", 32'(done_cnt), 0);
        pulse_stop();
        wait_idle(20, "loop_stop");
        loop_en = 1'b0;
        chk("loop_stop_level", 32'(fifo_level), 0);
        chk("loop_stop_no_done", 32'(done_cnt), 0);
        sample_ready = 1'b0;

        // stop while a read is outstanding
        clear_obs();
        ack_lat = 3;
        pulse_start(26'h400, 24'd5, 1'b0);
        n = 0;
        while (!(ack_cnt == 2 && bridge_read) && n < 100) begin tick(); n++; end
        chk("stop_reached", 32'(ack_cnt == 2 && bridge_read), 1);
        pulse_stop();
        chk("stop_read_held", 32'(bridge_read), 1);
        wait_idle(20, "stop");
        chk("stop_acks", 32'(ack_cnt), 3);
        chk("stop_level", 32'(fifo_level), 0);
        chk("stop_no_done", 32'(done_cnt), 0);
        ack_lat = 2;

        // zero-length start, then start and stop together
        clear_obs();
        base_addr = 26'h10; num_words = 24'd0; loop_en = 1'b0;
        start = 1'b1;
        s_cyc = cyc;
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("zero_done_cnt", 32'(done_cnt), 1);
        chk("zero_done_delay", 32'(done_cyc - s_cyc), 2);
        chk("zero_no_read", 32'(read_cycles), 0);
        chk("zero_busy", 32'(busy), 0);
        num_words = 24'd4;
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        repeat (3) tick();
        chk("startstop_busy", 32'(busy), 0);
        chk("startstop_no_read", 32'(read_cycles), 0);
        chk("startstop_no_done", 32'(done_cnt), 1);

        // reset in the middle of a read with five words buffered
        clear_obs();
        pulse_start(26'h800, 24'd10, 1'b0);
        n = 0;
        while (!(fifo_level == 5 && bridge_read) && n < 100) begin tick(); n++; end
        chk("rst_mid_reached", 32'(fifo_level == 5 && bridge_read), 1);
        #1 reset_reset_n = 1'b0;
        #1;
        chk("rst_mid_read", 32'(bridge_read), 0);
        chk("rst_mid_level", 32'(fifo_level), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        ack_en = 1'b0;
        repeat (2) tick();
        reset_reset_n = 1'b1;
        tick();
        spur_ack = 1'b1;
        tick();
        spur_ack = 1'b0;
        repeat (2) tick();
        chk("rst_spur_level", 32'(fifo_level), 0);
        chk("rst_spur_busy", 32'(busy), 0);
        ack_en = 1'b1;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
